// File: rtl/bt_uart_tx.sv
// 8N1 UART transmitter feeding the Bluetooth module's RX pin.
// Bytes enter a small FIFO through valid/ready and are serialised LSB first on TxD.
module bt_uart_tx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_AW      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               TxD,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  localparam int                DEPTH     = 1 << FIFO_AW;
  localparam int                CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]     BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]  FULL      = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  state_t             state;
  logic [CW-1:0]      baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic               push, pop, bit_done;

  // Readiness comes from the pre-edge count, so a same-cycle pop never lets a full FIFO accept.
  assign tx_ready = (fifo_count != FULL);
  assign push     = tx_valid && tx_ready;
  assign bit_done = (baud_cnt == BAUD_LAST);
  assign pop      = (fifo_count != '0) && ((state == IDLE) || (state == STOP && bit_done));
  assign busy     = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (tx_valid && !tx_ready) overflow <= 1'b1;
    end
  end

  // TxD is set on each transition so the pin is driven straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      TxD      <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          TxD <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= '0;
            TxD      <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            TxD      <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              TxD   <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              TxD     <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (pop) begin
              shift <= mem[rd_ptr];
              TxD   <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          TxD   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bt_uart_tx.sv
// Directed bench for bt_uart_tx: frame timing, FIFO flow control, reset abort,
// plus a default-rate instance for bit-period measurement.
module tb_bt_uart_tx;
  localparam int CPB = 4;
  localparam int DEF_CPB = 10416;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, TxD, busy, overflow;
  logic [2:0] fifo_count;
  logic [7:0] tx_data_d;
  logic       tx_valid_d;
  logic       tx_ready_d, TxD_d, busy_d, overflow_d;
  logic [2:0] fifo_count_d;

  int vectors = 0;
  int errors  = 0;

  bt_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .TxD(TxD), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  bt_uart_tx dut_d (
    .clk(clk), .rst(rst), .tx_data(tx_data_d), .tx_valid(tx_valid_d), .tx_ready(tx_ready_d),
    .TxD(TxD_d), .busy(busy_d), .fifo_count(fifo_count_d), .overflow(overflow_d)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected line level at position 0..9 of an 8N1 frame.
  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic seen_low;
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_valid_d = 1'b0; tx_data_d = 8'h00;
    repeat (3) @(posedge clk); #1;
    vectors++; if (TxD !== 1'b1) begin errors++; $display("FAIL rst_txd: got %b want 1", TxD); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    vectors++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", tx_ready); end
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    rst = 1'b0;
    tick();
    // Two zero bytes: one in flight, one queued; abort during data bit 3.
    tx_valid = 1'b1; tx_data = 8'h00;
    tick();
    tick();
    tx_valid = 1'b0;
    repeat (16) tick();
    vectors++; if (TxD !== 1'b0) begin errors++; $display("FAIL mid_bit3: got %b want 0", TxD); end
    vectors++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL mid_count: got %0d want 1", fifo_count); end
    #3 rst = 1'b1;
    #1;
    vectors++; if (TxD !== 1'b1) begin errors++; $display("FAIL abort_txd: got %b want 1", TxD); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    vectors++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL abort_count: got %0d want 0", fifo_count); end
    vectors++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", tx_ready); end
    @(posedge clk); #1 rst = 1'b0;
    seen_low = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (TxD !== 1'b1 || busy !== 1'b0) seen_low = 1'b1;
    end
    vectors++; if (seen_low !== 1'b0) begin errors++; $display("FAIL post_abort_idle: got activity=%b want 0", seen_low); end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0; tx_data = 8'hFF;
    @(negedge clk);
    vectors++; if (TxD !== 1'b1) begin errors++; $display("FAIL single_pre: got %b want 1", TxD); end
    vectors++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count1: got %0d want 1", fifo_count); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      vectors++;
      if (TxD !== frame_bit(8'hA5, k/4)) begin
        errors++; $display("FAIL single_bit k=%0d: got %b want %b", k, TxD, frame_bit(8'hA5, k/4));
      end
      if (k == 0) begin
        vectors++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_count0: got %0d want 0", fifo_count); end
      end
    end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_end: got %b want 1", busy); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b want 0", busy); end
    vectors++; if (TxD !== 1'b1) begin errors++; $display("FAIL single_idle: got %b want 1", TxD); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    @(posedge clk); #1;
    tx_data = 8'h55; tx_valid = 1'b1;
    tick();
    vectors++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL b2b_count_a: got %0d want 1", fifo_count); end
    tx_data = 8'h0F;
    tick();
    tx_valid = 1'b0; tx_data = 8'h00;
    vectors++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL b2b_count_b: got %0d want 1", fifo_count); end
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      b = (k < 40) ? 8'h55 : 8'h0F;
      vectors++;
      if (TxD !== frame_bit(b, (k%40)/4)) begin
        errors++; $display("FAIL b2b_bit k=%0d: got %b want %b", k, TxD, frame_bit(b, (k%40)/4));
      end
      if (k == 39) begin
        vectors++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL b2b_count_c: got %0d want 1", fifo_count); end
      end
      if (k == 40) begin
        vectors++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL b2b_count_d: got %0d want 0", fifo_count); end
      end
      if (k > 0 && k < 80) begin
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy k=%0d: got %b want 1", k, busy); end
      end
    end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_fall: got %b want 0", busy); end
  endtask

  task automatic test_full();
    logic [2:0] exp_cnt [6];
    logic       seen_low;
    exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    @(posedge clk); #1;
    fork
      begin
        @(posedge clk); @(posedge clk);
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          vectors++;
          if (TxD !== frame_bit(8'(k/40 + 1), (k%40)/4)) begin
            errors++; $display("FAIL full_bit k=%0d: got %b want %b", k, TxD, frame_bit(8'(k/40 + 1), (k%40)/4));
          end
        end
      end
      begin
        for (int i = 0; i < 6; i++) begin
          tx_data = 8'(i + 1); tx_valid = 1'b1;
          tick();
          vectors++;
          if (fifo_count !== exp_cnt[i]) begin
            errors++; $display("FAIL full_count i=%0d: got %0d want %0d", i, fifo_count, exp_cnt[i]);
          end
          if (i == 4) begin
            vectors++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", tx_ready); end
            vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_early: got %b want 0", overflow); end
          end
        end
        tx_valid = 1'b0;
        vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_ovf: got %b want 1", overflow); end
      end
    join
    seen_low = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_fall: got %b want 0", busy); end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (TxD !== 1'b1) seen_low = 1'b1;
    end
    vectors++; if (seen_low !== 1'b0) begin errors++; $display("FAIL full_dropped_sent: got activity=%b want 0", seen_low); end
    vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_ovf_sticky: got %b want 1", overflow); end
    #2 rst = 1'b1;
    #2;
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf_clear: got %b want 0", overflow); end
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    @(posedge clk); #1;
    fork
      begin
        @(posedge clk); @(posedge clk);
        for (int k = 0; k < 400; k++) begin
          @(negedge clk);
          vectors++;
          if (TxD !== frame_bit(8'(8'h10 + k/40), (k%40)/4)) begin
            errors++; $display("FAIL wrap_bit k=%0d: got %b want %b", k, TxD, frame_bit(8'(8'h10 + k/40), (k%40)/4));
          end
        end
      end
      begin
        int  idx;
        logic rdy;
        tx_data = 8'h10; tx_valid = 1'b1;
        tick();
        tx_data = 8'h11;
        tick();
        tx_data = 8'h12;
        tick();
        tx_valid = 1'b0;
        vectors++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL wrap_count_pre: got %0d want 2", fifo_count); end
        repeat (38) tick();
        tx_data = 8'h13; tx_valid = 1'b1;
        @(negedge clk);
        vectors++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL wrap_count_stop: got %0d want 2", fifo_count); end
        tick();
        vectors++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL wrap_count_pushpop: got %0d want 2", fifo_count); end
        idx = 4;
        for (int c = 0; c < 600 && idx < 10; c++) begin
          tx_data = 8'(8'h10 + idx); tx_valid = 1'b1;
          @(negedge clk);
          rdy = tx_ready;
          tick();
          if (rdy) idx++;
        end
        tx_valid = 1'b0;
        vectors++; if (idx != 10) begin errors++; $display("FAIL wrap_push_timeout: got %0d pushed want 10", idx); end
      end
    join
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_busy_fall: got %b want 0", busy); end
  endtask

  task automatic test_default();
    int         lo, hi, c;
    logic [3:0] nib;
    @(posedge clk); #1;
    tx_data_d = 8'h31; tx_valid_d = 1'b1;
    tick();
    tx_valid_d = 1'b0;
    c = 0;
    @(negedge clk);
    while (TxD_d !== 1'b0 && c < 20) begin c++; @(negedge clk); end
    vectors++; if (c >= 20) begin errors++; $display("FAIL def_start_timeout: got no start bit within %0d cycles", c); end
    vectors++; if (busy_d !== 1'b1) begin errors++; $display("FAIL def_busy: got %b want 1", busy_d); end
    lo = 0;
    while (TxD_d === 1'b0 && lo < 20000) begin lo++; @(negedge clk); end
    vectors++; if (lo != DEF_CPB) begin errors++; $display("FAIL def_start_len: got %0d want %0d", lo, DEF_CPB); end
    hi = 0;
    while (TxD_d === 1'b1 && hi < 20000) begin hi++; @(negedge clk); end
    vectors++; if (hi != DEF_CPB) begin errors++; $display("FAIL def_bit0_len: got %0d want %0d", hi, DEF_CPB); end
    nib[0] = (hi > 0);
    repeat (DEF_CPB/2) @(negedge clk);
    nib[1] = TxD_d;
    repeat (DEF_CPB) @(negedge clk);
    nib[2] = TxD_d;
    repeat (DEF_CPB) @(negedge clk);
    nib[3] = TxD_d;
    vectors++; if (nib !== 4'h1) begin errors++; $display("FAIL def_low_nibble: got %h want 1", nib); end
    #2 rst = 1'b1;
    #2;
    vectors++; if (TxD_d !== 1'b1) begin errors++; $display("FAIL def_abort_txd: got %b want 1", TxD_d); end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_wrap();
    test_default();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
